// File: rtl/core_config_pkg.sv
// core_config_pkg -- core-wide configuration constants and shared types.
//
// Contents:
//   XLEN            integer datapath / result width
//   REG_ADDR_W      architectural register address width
//   N_COMMIT_UNITS  number of ALU commiter interfaces served by commit_arbiter
//   commit_idx_t    encoded index of one commit unit
package core_config_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int N_COMMIT_UNITS = 4;

    typedef logic [$clog2(N_COMMIT_UNITS)-1:0] commit_idx_t;

endpackage

// File: rtl/commit_arbiter_rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin picker.
//
// Picks the first set bit of req at or after ptr, wrapping modulo N.
//
// Ports:
//   req    in   N      request vector
//   ptr    in   IDX_W  search start position (must be < N)
//   grant  out  N      one-hot grant (all zero when no request)
//   idx    out  IDX_W  encoded index of the granted bit (0 when none)
//   any    out  1      at least one request present
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // pos[k] is the unit index k steps after ptr; hit[k] is its request.
    logic [IDX_W:0]   sum [N];
    logic [IDX_W-1:0] pos [N];
    logic [N-1:0]     hit;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign sum[gi] = {1'b0, ptr} + (IDX_W+1)'(gi);
            // Explicit wrap so non-power-of-two N also works.
            assign pos[gi] = (sum[gi] >= (IDX_W+1)'(N))
                           ? IDX_W'(sum[gi] - (IDX_W+1)'(N))
                           : sum[gi][IDX_W-1:0];
            assign hit[gi] = req[pos[gi]];
        end
    endgenerate

    // Scan from the far end back to offset 0 so the closest hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = pos[k];
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter -- commit-side arbiter for the ALU commiter interfaces.
//
// Collects finished results from N_UNITS ALUs, grants at most one per cycle
// (round-robin, with units asserting unit_req taking precedence), drives the
// register-file write port one cycle later and pulses unit_clear back to the
// granted unit in the grant cycle. Erroring results are reported on
// exc_valid/exc_unit instead of being written back; writes to x0 are dropped.
//
// Optional build macro: COMMIT_ARB_STATS_EN adds stat_commits (grants) and
// stat_conflicts (cycles with two or more candidates), both 32-bit wrapping.
//
// Ports:
//   clk            in   1                   core clock, rising edge
//   rst            in   1                   asynchronous active-high reset
//   unit_valid     in   N_UNITS             per-unit result valid
//   unit_req       in   N_UNITS             per-unit priority request
//   unit_res       in   N_UNITS*XLEN        packed results
//   unit_rd        in   N_UNITS*REG_ADDR_W  packed destination registers
//   unit_error     in   N_UNITS             per-unit error flag
//   unit_clear     out  N_UNITS             one-hot combinational grant/release
//   stall          in   1                   suppresses all grants while high
//   wr_en          out  1                   register-file write enable
//   wr_addr        out  REG_ADDR_W          register-file write address
//   wr_data        out  XLEN                register-file write data
//   exc_valid      out  1                   one-cycle error report
//   exc_unit       out  $clog2(N_UNITS)     erroring unit index
//   stat_commits   out  32                  (stats build only) grant count
//   stat_conflicts out  32                  (stats build only) conflict count
import core_config_pkg::*;

module commit_arbiter #(
    parameter int N_UNITS    = core_config_pkg::N_COMMIT_UNITS,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_UNITS-1:0]            unit_valid,
    input  logic [N_UNITS-1:0]            unit_req,
    input  logic [N_UNITS*XLEN-1:0]       unit_res,
    input  logic [N_UNITS*REG_ADDR_W-1:0] unit_rd,
    input  logic [N_UNITS-1:0]            unit_error,
    output logic [N_UNITS-1:0]            unit_clear,
    input  logic                          stall,
    output logic                          wr_en,
    output logic [REG_ADDR_W-1:0]         wr_addr,
    output logic [XLEN-1:0]               wr_data,
    output logic                          exc_valid,
    output logic [$clog2(N_UNITS)-1:0]    exc_unit
`ifdef COMMIT_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_commits,
    output logic [31:0]                   stat_conflicts
`endif
);

    localparam int IDX_W = $clog2(N_UNITS);

    logic [IDX_W-1:0]   rr_ptr;

    logic [N_UNITS-1:0] cand;
    logic [N_UNITS-1:0] pri_cand;
    logic [N_UNITS-1:0] pri_grant;
    logic [N_UNITS-1:0] norm_grant;
    logic [IDX_W-1:0]   pri_idx;
    logic [IDX_W-1:0]   norm_idx;
    logic               pri_any;
    logic               norm_any;

    logic [N_UNITS-1:0]    win_grant;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_res;
    logic                  win_err;
    logic [IDX_W-1:0]      rr_ptr_next;

    assign cand     = unit_valid & ~{N_UNITS{stall}};
    assign pri_cand = cand & unit_req;

    // Two pools share the same pointer; the priority pool wins whenever it
    // has any member, otherwise every candidate competes.
    rr_arbiter #(.N(N_UNITS), .IDX_W(IDX_W)) u_pri_arb (
        .req   (pri_cand),
        .ptr   (rr_ptr),
        .grant (pri_grant),
        .idx   (pri_idx),
        .any   (pri_any)
    );

    rr_arbiter #(.N(N_UNITS), .IDX_W(IDX_W)) u_norm_arb (
        .req   (cand),
        .ptr   (rr_ptr),
        .grant (norm_grant),
        .idx   (norm_idx),
        .any   (norm_any)
    );

    assign win_grant = pri_any ? pri_grant : norm_grant;
    assign win_idx   = pri_any ? pri_idx   : norm_idx;
    assign win_any   = norm_any;

    assign win_rd  = unit_rd[int'(win_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign win_res = unit_res[int'(win_idx)*XLEN +: XLEN];
    assign win_err = unit_error[win_idx];

    assign rr_ptr_next = (win_idx == IDX_W'(N_UNITS - 1)) ? '0 : win_idx + 1'b1;

    // Masked by rst so no ALU is released while the whole domain is in reset.
    assign unit_clear = rst ? '0 : win_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            exc_valid <= 1'b0;
            exc_unit  <= '0;
        end else begin
            wr_en     <= 1'b0;
            exc_valid <= 1'b0;
            if (win_any) begin
                rr_ptr <= rr_ptr_next;
                if (win_err) begin
                    exc_valid <= 1'b1;
                    exc_unit  <= win_idx;
                end else if (win_rd != '0) begin
                    // x0 results are released but never written.
                    wr_en   <= 1'b1;
                    wr_addr <= win_rd;
                    wr_data <= win_res;
                end
            end
        end
    end

`ifdef COMMIT_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_commits   <= '0;
            stat_conflicts <= '0;
        end else begin
            if (win_any) begin
                stat_commits <= stat_commits + 32'd1;
            end
            if ($countones(cand) >= 2) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not present in this build.
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter -- directed plus randomized bench for commit_arbiter.
// A behavioural model (rotational-distance winner selection, per-unit ALU
// hold/release) predicts unit_clear and the registered commit outputs.
module tb_commit_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   unit_valid;
    logic [3:0]   unit_req;
    logic [127:0] unit_res;
    logic [19:0]  unit_rd;
    logic [3:0]   unit_error;
    logic [3:0]   unit_clear;
    logic         stall;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         exc_valid;
    logic [1:0]   exc_unit;
`ifdef COMMIT_ARB_STATS_EN
    logic [31:0]  stat_commits;
    logic [31:0]  stat_conflicts;
`endif

    logic [31:0] res_a [N];
    logic [4:0]  rd_a  [N];

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int          ptr;
    logic        e_wr_en;
    logic        e_exc;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_unit;

    always #5 clk = ~clk;

    always_comb begin
        unit_res = '0;
        unit_rd  = '0;
        for (int i = 0; i < N; i++) begin
            unit_res[i*32 +: 32] = res_a[i];
            unit_rd[i*5 +: 5]    = rd_a[i];
        end
    end

    commit_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .unit_valid (unit_valid),
        .unit_req   (unit_req),
        .unit_res   (unit_res),
        .unit_rd    (unit_rd),
        .unit_error (unit_error),
        .unit_clear (unit_clear),
        .stall      (stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .exc_valid  (exc_valid),
        .exc_unit   (exc_unit)
`ifdef COMMIT_ARB_STATS_EN
        ,
        .stat_commits   (stat_commits),
        .stat_conflicts (stat_conflicts)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = candidate with the smallest rotational distance from ptr,
    // restricted to req-set candidates when any exist.
    function automatic int pick(input logic [3:0] v, input logic [3:0] r,
                                input logic st, input int p);
        logic [3:0] pool;
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        if (st) return -1;
        pool = ((v & r) != 4'b0) ? (v & r) : v;
        for (int i = 0; i < N; i++) begin
            if (pool[i]) begin
                d = (i - p + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        int w;
        logic [3:0] e_clr;
        #1;
        w = pick(unit_valid, unit_req, stall, ptr);
        e_clr = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        check("unit_clear", 64'(unit_clear), 64'(e_clr));
        @(posedge clk);
        e_wr_en = 1'b0;
        e_exc   = 1'b0;
        if (w >= 0) begin
            ptr = (w + 1) % N;
            if (unit_error[w]) begin
                e_exc  = 1'b1;
                e_unit = w[1:0];
            end else if (rd_a[w] != 5'd0) begin
                e_wr_en = 1'b1;
                e_addr  = rd_a[w];
                e_data  = res_a[w];
            end
            $display("t=%0t grant unit %0d rd=%0d err=%0b res=%h", $time, w, rd_a[w], unit_error[w], res_a[w]);
        end else begin
            $display("t=%0t no grant stall=%0b valid=%b", $time, stall, unit_valid);
        end
        #1;
        // Granted ALU drops its result after the clear.
        if (w >= 0) begin
            unit_valid[w] = 1'b0;
            unit_req[w]   = 1'b0;
            unit_error[w] = 1'b0;
        end
        check("wr_en", 64'(wr_en), 64'(e_wr_en));
        check("exc_valid", 64'(exc_valid), 64'(e_exc));
        check("wr_addr", 64'(wr_addr), 64'(e_addr));
        check("wr_data", 64'(wr_data), 64'(e_data));
        if (e_exc) check("exc_unit", 64'(exc_unit), 64'(e_unit));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        unit_valid = 4'b1111;   // clear must stay low regardless
        #1;
        check("rst_unit_clear", 64'(unit_clear), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_exc_valid", 64'(exc_valid), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_exc_unit", 64'(exc_unit), 64'(0));
        @(negedge clk);
        rst        = 1'b0;
        unit_valid = 4'b0;
        unit_req   = 4'b0;
        unit_error = 4'b0;
        ptr     = 0;
        e_wr_en = 1'b0;
        e_exc   = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        e_unit  = '0;
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        unit_valid = 4'b0;
        unit_req   = 4'b0;
        unit_error = 4'b0;
        for (int i = 0; i < N; i++) begin
            res_a[i] = '0;
            rd_a[i]  = '0;
        end
        @(negedge clk);
        do_reset();

        // All four valid from ptr 0, rd = 1..4.
        for (int i = 0; i < N; i++) begin
            rd_a[i]  = 5'(i + 1);
            res_a[i] = $urandom;
        end
        unit_valid = 4'b1111;
        repeat (4) cycle();
        cycle();   // idle: wr_en must drop

        // Single unit 2, rd 7.
        rd_a[2]    = 5'd7;
        res_a[2]   = 32'hDEADBEEF;
        unit_valid = 4'b0100;
        cycle();

        // Error on unit 1.
        rd_a[1]       = 5'd9;
        res_a[1]      = 32'h0;
        unit_error[1] = 1'b1;
        unit_valid    = 4'b0010;
        cycle();

        // Bring pointer back to 0 via unit 3.
        rd_a[3]    = 5'd5;
        res_a[3]   = 32'h1234_5678;
        unit_valid = 4'b1000;
        cycle();

        // x0 on unit 0 competing with a priority request on unit 3.
        rd_a[0]     = 5'd0;
        res_a[0]    = 32'hCAFE_F00D;
        rd_a[3]     = 5'd12;
        res_a[3]    = 32'h0BAD_0BAD;
        unit_req[3] = 1'b1;
        unit_valid  = 4'b1001;
        cycle();
        cycle();

        // Stall for three cycles with unit 0 pending.
        rd_a[0]    = 5'd3;
        res_a[0]   = 32'hA5A5_5A5A;
        unit_valid = 4'b0001;
        stall      = 1'b1;
        repeat (3) cycle();
        stall = 1'b0;
        cycle();

        // Reset during a grant cycle while a write is still being presented.
        rd_a[1]    = 5'd17;
        res_a[1]   = 32'h1111_2222;
        unit_valid = 4'b0010;
        cycle();
        rd_a[2]    = 5'd18;
        unit_valid = 4'b0100;
        #1;
        check("pre_rst_clear", 64'(unit_clear), 64'(4'b0100));
        rst = 1'b1;
        #1;
        check("async_wr_en", 64'(wr_en), 64'(0));
        check("async_exc_valid", 64'(exc_valid), 64'(0));
        check("async_unit_clear", 64'(unit_clear), 64'(0));
        @(negedge clk);
        do_reset();
        // Pointer back at 0: all four served 0,1,2,3.
        for (int i = 0; i < N; i++) begin
            rd_a[i]  = 5'(20 + i);
            res_a[i] = $urandom;
        end
        unit_valid = 4'b1111;
        repeat (4) cycle();

        // Randomized traffic.
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                if (!unit_valid[i] && $urandom_range(0, 2) == 0) begin
                    unit_valid[i] = 1'b1;
                    rd_a[i]       = 5'($urandom_range(0, 31));
                    res_a[i]      = $urandom;
                    unit_error[i] = ($urandom_range(0, 7) == 0);
                    unit_req[i]   = ($urandom_range(0, 3) == 0);
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
